data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 26 ++
 rtl/data_mem_responder_if.sv | 33 +++
 rtl/data_mem_responder_array.sv | 38 +++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 tb/tb_data_mem_responder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// Module   : dmem_pkg
// Brief    : Shared types and constants for the data memory responder.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  localparam int DMEM_WORD_W  = 32;
  localparam int DMEM_BE_W    = 4;
  localparam int DMEM_CAUSE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [DMEM_CAUSE_W-1:0] DMEM_ERR_NONE     = 2'd0;
  localparam logic [DMEM_CAUSE_W-1:0] DMEM_ERR_MISALIGN = 2'd1;
  localparam logic [DMEM_CAUSE_W-1:0] DMEM_ERR_RANGE    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// Module   : data_mem_responder_if
// Brief    : Load/store request/response bundle between core and data memory.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface data_mem_responder_if;
  import dmem_pkg::*;

  logic                   req_i;
  logic                   we_i;
  logic [DMEM_WORD_W-1:0] addr_i;
  logic [DMEM_WORD_W-1:0] wdata_i;
  logic [DMEM_BE_W-1:0]   be_i;
  logic                   ready_o;
  logic [DMEM_WORD_W-1:0] rdata_o;
  logic                   err_o;
  logic                   busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  ready_o, rdata_o, err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output ready_o, rdata_o, err_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/data_mem_responder_array.sv
// ----------------------------------------------------------------------------
// Module   : dmem_array
// Brief    : DEPTH_WORDS x 32 storage, per-byte write enable, async read port.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 128,
  localparam int c_AW        = $clog2(DEPTH_WORDS)
) (
  input  wire logic                   clk_i,
  input  wire logic                   i_we,
  input  wire logic [DMEM_BE_W-1:0]   i_be,
  input  wire logic [c_AW-1:0]        i_addr,
  input  wire logic [DMEM_WORD_W-1:0] i_wdata,
  output logic      [DMEM_WORD_W-1:0] o_rdata
);

  logic [DMEM_WORD_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      for (int k = 0; k < DMEM_BE_W; k++) begin
        if (i_be[k]) begin
          r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// Module   : data_mem_responder
// Brief    : Wait-state data memory responder: FSM, request latch, error decode.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  data_mem_responder_if.slave bus
);

  localparam int         c_AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_e r_state;
  dmem_state_e w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_next_cnt;

  logic                          r_we;
  logic [DMEM_WORD_W-1:0]        r_addr;
  logic [DMEM_WORD_W-1:0]        r_wdata;
  logic [DMEM_BE_W-1:0]          r_be;

  logic                          w_resp;
  logic                          w_accept;
  logic [DMEM_CAUSE_W-1:0]       w_cause;
  logic                          w_err;
  logic                          w_wr_en;
  logic [c_AW-1:0]               w_idx;
  logic [DMEM_WORD_W-1:0]        w_rd;

  assign w_resp   = (r_state == RESP);
  assign w_accept = bus.req_i && ((r_state == IDLE) || w_resp);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE, RESP: begin
        if (bus.req_i) begin
          if (LATENCY == 0) begin
            w_next_state = RESP;
          end else begin
            w_next_state = WAIT;
            w_next_cnt   = c_WAIT_LOAD;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = RESP;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_we    <= bus.we_i;
        r_addr  <= bus.addr_i;
        r_wdata <= bus.wdata_i;
        r_be    <= bus.be_i;
      end
    end
  end

  // Depth is a power of two, so any set bit above the index field is out of range.
  always_comb begin
    w_cause = DMEM_ERR_NONE;
    if (r_addr[1:0] != 2'b00) begin
      w_cause = DMEM_ERR_MISALIGN;
    end else if (|(r_addr >> (c_AW + 2))) begin
      w_cause = DMEM_ERR_RANGE;
    end
  end

  assign w_err   = (w_cause != DMEM_ERR_NONE);
  assign w_idx   = r_addr[c_AW+1:2];
  assign w_wr_en = w_resp && r_we && !w_err && !rst_i;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .i_we    (w_wr_en),
    .i_be    (r_be),
    .i_addr  (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rd)
  );

  assign bus.ready_o = w_resp;
  assign bus.err_o   = w_resp && w_err;
  assign bus.rdata_o = (w_resp && !r_we && !w_err) ? w_rd : '0;
  assign bus.busy_o  = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// Module   : tb_data_mem_responder
// Brief    : Random + directed checks of two responders (LATENCY 0 and 2).
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_responder;

  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic        s_req   [2];
  logic        s_we    [2];
  logic [31:0] s_addr  [2];
  logic [31:0] s_wdata [2];
  logic [3:0]  s_be    [2];
  logic        o_ready [2];
  logic        o_err   [2];
  logic        o_busy  [2];
  logic [31:0] o_rdata [2];

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  assign bus0.req_i   = s_req[0];
  assign bus0.we_i    = s_we[0];
  assign bus0.addr_i  = s_addr[0];
  assign bus0.wdata_i = s_wdata[0];
  assign bus0.be_i    = s_be[0];
  assign o_ready[0]   = bus0.ready_o;
  assign o_err[0]     = bus0.err_o;
  assign o_busy[0]    = bus0.busy_o;
  assign o_rdata[0]   = bus0.rdata_o;

  assign bus1.req_i   = s_req[1];
  assign bus1.we_i    = s_we[1];
  assign bus1.addr_i  = s_addr[1];
  assign bus1.wdata_i = s_wdata[1];
  assign bus1.be_i    = s_be[1];
  assign o_ready[1]   = bus1.ready_o;
  assign o_err[1]     = bus1.err_o;
  assign o_busy[1]    = bus1.busy_o;
  assign o_rdata[1]   = bus1.rdata_o;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
    .clk_i (clk), .rst_i (rst[0]), .bus (bus0)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut1 (
    .clk_i (clk), .rst_i (rst[1]), .bus (bus1)
  );

  int          lat [2] = '{0, 2};
  logic [31:0] model [2][DEPTH];
  logic [31:0] last_rdata;
  int          n_checks = 0;
  int          n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  // One isolated transaction; the expected response comes from the word model.
  task automatic txn(input int b, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input string tag);
    int          waited;
    bit          seen;
    bit          bad;
    logic [31:0] exp_rd;
    bad    = addr_bad(addr);
    exp_rd = (we || bad) ? 32'h0 : model[b][int'(addr >> 2)];
    @(negedge clk);
    s_we[b] = we; s_addr[b] = addr; s_wdata[b] = wdata; s_be[b] = be; s_req[b] = 1'b1;
    @(posedge clk);
    #1 s_req[b] = 1'b0;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      waited++;
      if (waited == 1) check($sformatf("%s_busy", tag), 32'(o_busy[b]), 32'd1);
      if (o_ready[b] === 1'b1) seen = 1'b1;
    end
    check($sformatf("%s_ready", tag), 32'(seen), 32'd1);
    check($sformatf("%s_lat", tag), 32'(waited), 32'(lat[b] + 1));
    check($sformatf("%s_err", tag), 32'(o_err[b]), 32'(bad));
    check($sformatf("%s_rdata", tag), o_rdata[b], exp_rd);
    last_rdata = o_rdata[b];
    if (we && !bad) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) model[b][int'(addr >> 2)][8*k +: 8] = wdata[8*k +: 8];
      end
    end
    @(negedge clk);
    check($sformatf("%s_pulse", tag), 32'(o_ready[b]), 32'd0);
  endtask

  initial begin
    logic [31:0] old;
    logic [31:0] a;
    int          b;
    int          sel;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; s_req[i] = 1'b0; s_we[i] = 1'b0;
      s_addr[i] = '0; s_wdata[i] = '0; s_be[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d_ready", i), 32'(o_ready[i]), 32'd0);
      check($sformatf("rst%0d_err", i),   32'(o_err[i]),   32'd0);
      check($sformatf("rst%0d_rdata", i), o_rdata[i],      32'd0);
      check($sformatf("rst%0d_busy", i),  32'(o_busy[i]),  32'd0);
    end

    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < DEPTH; w++) begin
        txn(i, 1'b1, 32'(w * 4), $urandom, 4'hF, "init");
      end
    end

    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10");
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, "ld10");
    check("tp_full_word", last_rdata, 32'hDEADBEEF);
    txn(1, 1'b1, 32'h10, 32'h000000AA, 4'b0001, "st10_b0");
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, "ld10_b0");
    check("tp_partial", last_rdata, 32'hDEADBEAA);
    txn(1, 1'b0, 32'h12, 32'h0, 4'h0, "ld_misalign");
    txn(1, 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, "ld_range");
    txn(1, 1'b1, 32'h201, 32'h11111111, 4'hF, "st_err201");
    txn(1, 1'b0, 32'h200, 32'h0, 4'h0, "ld200");
    old = model[1][16];
    txn(1, 1'b1, 32'h41, 32'h11111111, 4'hF, "st_err41");
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, "ld40");
    check("tp_err_store", last_rdata, old);
    txn(1, 1'b1, 32'h44, 32'hCAFEF00D, 4'h0, "st_be0");
    txn(1, 1'b0, 32'h44, 32'h0, 4'h0, "ld_be0");

    // Back-to-back loads with req held on the zero-latency instance.
    @(negedge clk);
    s_we[0] = 1'b0; s_be[0] = 4'h0; s_addr[0] = 32'h0; s_req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) s_addr[0] = 32'(4 * (i + 1));
      else       s_req[0]  = 1'b0;
      @(negedge clk);
      check($sformatf("b2b%0d_ready", i), 32'(o_ready[0]), 32'd1);
      check($sformatf("b2b%0d_err", i),   32'(o_err[0]),   32'd0);
      check($sformatf("b2b%0d_rdata", i), o_rdata[0],      model[0][i]);
    end
    @(negedge clk);
    check("b2b_end_ready", 32'(o_ready[0]), 32'd0);

    // Reset during WAIT drops the store.
    old = model[1][8];
    @(negedge clk);
    s_we[1] = 1'b1; s_addr[1] = 32'h20; s_wdata[1] = 32'h12345678; s_be[1] = 4'hF; s_req[1] = 1'b1;
    @(posedge clk);
    #1 s_req[1] = 1'b0;
    @(negedge clk);
    check("rstw_ready", 32'(o_ready[1]), 32'd0);
    check("rstw_busy",  32'(o_busy[1]),  32'd1);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstw_ready_after", 32'(o_ready[1]), 32'd0);
    check("rstw_err_after",   32'(o_err[1]),   32'd0);
    check("rstw_rdata_after", o_rdata[1],      32'd0);
    check("rstw_busy_after",  32'(o_busy[1]),  32'd0);
    rst[1] = 1'b0;
    @(negedge clk);
    check("rstw_idle_ready", 32'(o_ready[1]), 32'd0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, "rstw_ld20");
    check("rstw_old_data", last_rdata, old);

    // Reset during RESP must suppress the pending store.
    old = model[0][9];
    @(negedge clk);
    s_we[0] = 1'b1; s_addr[0] = 32'h24; s_wdata[0] = ~old; s_be[0] = 4'hF; s_req[0] = 1'b1;
    @(posedge clk);
    #1 s_req[0] = 1'b0;
    @(negedge clk);
    check("rstr_in_resp", 32'(o_ready[0]), 32'd1);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstr_busy_after", 32'(o_busy[0]), 32'd0);
    rst[0] = 1'b0;
    txn(0, 1'b0, 32'h24, 32'h0, 4'h0, "rstr_ld24");
    check("rstr_old_data", last_rdata, old);

    for (int n = 0; n < 300; n++) begin
      b   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel <= 6)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (sel == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 8) a = (32'(DEPTH) + 32'($urandom_range(0, 100000))) << 2;
      else               a = $urandom | 32'h1;
      txn(b, 1'($urandom), a, $urandom, 4'($urandom), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
